key_search_ctrl: RTL
====================

// Module: key_search_ctrl
// PURPOSE
//  Brute-force RC4 key-search sequencer for the S/EM/DM datapath.
//  For each candidate key it runs the init, shuffle and decrypt loops in order. It owns S-memory port
//  selection. It snoops DM writes and flags the key good if every decrypted byte is 'a'..'z' or space.
//  On a bad key it increments the key and restarts, until a key passes or KEY_MAX is exhausted.
// PARAMETERS
//  KEY_W      24        candidate key width fed to shuffle loop
//  KEY_MAX    24'h3FFFFF last key tried; search space is key_first..KEY_MAX
//  MSG_LEN    32        decrypted bytes per key (DM addresses 0..MSG_LEN-1)
//  TIMEOUT    1024      max cycles any single stage may run before abort
// PORTS
//  clk          in   1      system clock (CLOCK_50)
//  reset_n      in   1      async active-low reset (KEY[3])
//  start        in   1      level/pulse; sampled only in IDLE
//  key_first    in   KEY_W  first key tried; latched on accepted start
//  stage_start  out  3      one-cycle one-hot pulse: [0]=init [1]=shuffle [2]=decrypt
//  stage_done   in   3      one-cycle one-hot pulse from matching loop
//  mem_sel      out  2      S-mem mux select: 0=init 1=shuffle 2=decrypt 3=none (wren forced 0 downstream)
//  key          out  KEY_W  current candidate key, stable through a whole attempt
//  dm_wren      in   1      snoop of DM write enable
//  dm_wrdata    in   8      snoop of DM write data
//  busy         out  1      high from accepted start until FOUND/FAIL
//  found        out  1      sticky; key holds the passing key
//  fail         out  1      sticky; space exhausted or stage timeout
//  timeout_err  out  1      sticky; fail was caused by timeout
// BEHAVIOUR
//  Reset: state=IDLE, stage_start=0, mem_sel=3, key=0, busy=0, found=0, fail=0, timeout_err=0, bad=0, tcnt=0.
//  FSM states: IDLE, INIT, SHUFFLE, DECRYPT, CHECK, NEXT_KEY, FOUND, FAIL.
//  IDLE: start=1 -> key<=key_first, busy<=1, clear found/fail/timeout_err; next cycle enters INIT.
//  Entering INIT/SHUFFLE/DECRYPT: pulse the matching stage_start bit for exactly one cycle (first cycle in state).
//   mem_sel=0/1/2 for the whole state. tcnt<=0 on entry.
//  Each stage state waits for its own stage_done bit, then moves INIT->SHUFFLE->DECRYPT->CHECK.
//   stage_done bits for other stages are ignored.
//  DECRYPT: each dm_wren=1 cycle checks dm_wrdata; if not in 8'h61..8'h7A and not 8'h20, bad<=1 (sticky per key).
//   dm_wren outside DECRYPT is ignored. A bad byte in the same cycle as stage_done[2] still sets bad.
//   bad must be used by CHECK one cycle later.
//  CHECK (1 cycle, mem_sel=3): bad=0 -> FOUND. bad=1 and key==KEY_MAX -> FAIL. Otherwise -> NEXT_KEY.
//  NEXT_KEY (1 cycle): key<=key+1, bad<=0, -> INIT. Per-key latency = stage latencies + 2 cycles overhead.
//  FOUND: busy<=0, found<=1, key frozen, mem_sel=3. FAIL: busy<=0, fail<=1, mem_sel=3.
//   Both states hold until start=1, which re-arms exactly as from IDLE.
//  Timeout: tcnt increments each cycle in INIT/SHUFFLE/DECRYPT.
//   tcnt==TIMEOUT-1 without stage_done -> FAIL with timeout_err=1.
//  key_first > KEY_MAX: accepted; one attempt runs, then FAIL unless it passes. No wrap past KEY_MAX.
//  start while busy: ignored. Async reset mid-operation returns to reset values immediately, with no stage_start glitch.
//  All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Package ksa_pkg: typedef enum logic [2:0] ks_state_t; MEM_SEL_INIT/SHUF/DEC/NONE localparams;
//   CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SPACE=8'h20.
//  Sub-module char_checker: combinational, 8-bit in -> valid bit. Reused by display/verify logic.
//  Replaces the fixed done-flag muxing in the top level. The top ties mem_sel to the S-mem data/addr/wren mux.
// TESTING
//  1 key_first=0, model accepts 24'h000249 only -> found=1, key=24'h000249, 0x24A attempts, busy falls with found.
//  2 key_first=0, first DM byte of each attempt 8'h41 -> key advances by 1 each CHECK/NEXT_KEY, no FOUND.
//  3 key_first=KEY_MAX, bad byte -> fail=1, timeout_err=0, key stays KEY_MAX.
//  4 shuffle never returns stage_done -> fail=1, timeout_err=1 exactly TIMEOUT cycles after shuffle start.
//  5 reset_n low mid DECRYPT, then start with key_first=5 -> mem_sel=3, all flags 0, next attempt uses key 5 with clean bad.
//  6 start pulsed in SHUFFLE, plus stray stage_done[2] in INIT -> no state change, key and stage order unaffected.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-search sequencer and its helpers.
package ksa_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INIT     = 3'd1,
      S_SHUFFLE  = 3'd2,
      S_DECRYPT  = 3'd3,
      S_CHECK    = 3'd4,
      S_NEXT_KEY = 3'd5,
      S_FOUND    = 3'd6,
      S_FAIL     = 3'd7
   } ks_state_t;

   localparam logic [1:0] MEM_SEL_INIT = 2'd0;
   localparam logic [1:0] MEM_SEL_SHUF = 2'd1;
   localparam logic [1:0] MEM_SEL_DEC  = 2'd2;
   localparam logic [1:0] MEM_SEL_NONE = 2'd3;

   localparam logic [7:0] CHAR_LO    = 8'h61;
   localparam logic [7:0] CHAR_HI    = 8'h7A;
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   // S-memory owner for a given sequencer state; NONE also gates wren downstream.
   function automatic logic [1:0] mem_sel_for(input ks_state_t s);
      case (s)
         S_INIT:    return MEM_SEL_INIT;
         S_SHUFFLE: return MEM_SEL_SHUF;
         S_DECRYPT: return MEM_SEL_DEC;
         default:   return MEM_SEL_NONE;
      endcase
   endfunction

   function automatic logic is_stage(input ks_state_t s);
      return (s == S_INIT) || (s == S_SHUFFLE) || (s == S_DECRYPT);
   endfunction

endpackage

// File: rtl/char_checker.sv
// Plaintext character filter: lowercase letter or space counts as a valid decrypted byte.
module char_checker
   import ksa_pkg::*;
(
   input  logic [7:0] data,
   output logic       valid
);

   assign valid = ((data >= CHAR_LO) && (data <= CHAR_HI)) || (data == CHAR_SPACE);

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force RC4 key-search sequencer: runs init/shuffle/decrypt per candidate key,
// snoops DM writes for a plaintext-looking message and advances the key until one passes.
module key_search_ctrl
   import ksa_pkg::*;
#(
   parameter int               KEY_W   = 24,
   parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF,
   parameter int               MSG_LEN = 32,
   parameter int               TIMEOUT = 1024
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [KEY_W-1:0] key_first,
   output logic [2:0]       stage_start,
   input  logic [2:0]       stage_done,
   output logic [1:0]       mem_sel,
   output logic [KEY_W-1:0] key,
   input  logic             dm_wren,
   input  logic [7:0]       dm_wrdata,
   output logic             busy,
   output logic             found,
   output logic             fail,
   output logic             timeout_err,
   output logic [2:0]       state_dbg
);

   localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int BCNT_W = $clog2(MSG_LEN + 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
   localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(MSG_LEN);

   ks_state_t         state, next_state;
   logic [TCNT_W-1:0] tcnt, tcnt_d;
   logic [BCNT_W-1:0] bcnt, bcnt_d;
   logic              bad, bad_d;
   logic [KEY_W-1:0]  key_d;
   logic [2:0]        stage_start_d;
   logic [1:0]        mem_sel_d;
   logic              busy_d, found_d, fail_d, timeout_err_d;
   logic              char_ok, accept, timeout_hit, checked;

   char_checker u_char_checker (
      .data  (dm_wrdata),
      .valid (char_ok)
   );

   assign state_dbg = state;
   assign accept    = start && ((state == S_IDLE) || (state == S_FOUND) || (state == S_FAIL));
   assign checked   = (state == S_DECRYPT) && dm_wren && (bcnt < BCNT_MAX);

   // Stage handshake: stage_start[i] is a one-cycle pulse on the first cycle of the
   // stage state; the loop answers with a one-cycle stage_done[i]. Only the bit of the
   // active stage is honoured; anything else on stage_done is dropped.
   always_comb begin
      next_state  = state;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE, S_FOUND, S_FAIL: begin
            if (start) next_state = S_INIT;
         end
         S_INIT: begin
            if (stage_done[0]) next_state = S_SHUFFLE;
            else if (tcnt == TCNT_LAST) begin
               next_state  = S_FAIL;
               timeout_hit = 1'b1;
            end
         end
         S_SHUFFLE: begin
            if (stage_done[1]) next_state = S_DECRYPT;
            else if (tcnt == TCNT_LAST) begin
               next_state  = S_FAIL;
               timeout_hit = 1'b1;
            end
         end
         S_DECRYPT: begin
            if (stage_done[2]) next_state = S_CHECK;
            else if (tcnt == TCNT_LAST) begin
               next_state  = S_FAIL;
               timeout_hit = 1'b1;
            end
         end
         S_CHECK: begin
            // >= so a key_first above KEY_MAX gets exactly one attempt and never wraps
            if (!bad)               next_state = S_FOUND;
            else if (key >= KEY_MAX) next_state = S_FAIL;
            else                    next_state = S_NEXT_KEY;
         end
         S_NEXT_KEY: next_state = S_INIT;
         default:    next_state = S_IDLE;
      endcase
   end

   always_comb begin
      stage_start_d = 3'b000;
      if (next_state != state) begin
         case (next_state)
            S_INIT:    stage_start_d = 3'b001;
            S_SHUFFLE: stage_start_d = 3'b010;
            S_DECRYPT: stage_start_d = 3'b100;
            default:   stage_start_d = 3'b000;
         endcase
      end
      mem_sel_d     = mem_sel_for(next_state);
      busy_d        = !((next_state == S_IDLE) || (next_state == S_FOUND) || (next_state == S_FAIL));
      found_d       = (next_state == S_FOUND);
      fail_d        = (next_state == S_FAIL);
      timeout_err_d = timeout_hit || ((state == S_FAIL) && (next_state == S_FAIL) && timeout_err);
      tcnt_d        = ((next_state == state) && is_stage(state)) ? tcnt + 1'b1 : '0;

      key_d = key;
      if (accept)                   key_d = key_first;
      else if (state == S_NEXT_KEY) key_d = key + 1'b1;

      bad_d = bad;
      if (accept || (state == S_NEXT_KEY)) bad_d = 1'b0;
      else if (checked && !char_ok)        bad_d = 1'b1;

      bcnt_d = '0;
      if ((state == S_DECRYPT) && (next_state == S_DECRYPT))
         bcnt_d = checked ? bcnt + 1'b1 : bcnt;
      else if (state == S_DECRYPT)
         bcnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         stage_start <= 3'b000;
         mem_sel     <= MEM_SEL_NONE;
         key         <= '0;
         busy        <= 1'b0;
         found       <= 1'b0;
         fail        <= 1'b0;
         timeout_err <= 1'b0;
         bad         <= 1'b0;
         tcnt        <= '0;
         bcnt        <= '0;
      end else begin
         state       <= next_state;
         stage_start <= stage_start_d;
         mem_sel     <= mem_sel_d;
         key         <= key_d;
         busy        <= busy_d;
         found       <= found_d;
         fail        <= fail_d;
         timeout_err <= timeout_err_d;
         bad         <= bad_d;
         tcnt        <= tcnt_d;
         bcnt        <= bcnt_d;
      end
   end

endmodule
